// File: rtl/lowx_arbiter.sv
// lowx_arbiter: arbitrates dcache/icache line requests onto a single-word memory port.
// Define LOWX_ARB_RR_EN for round-robin grant; otherwise dcache has fixed priority.
module lowx_arbiter #(
    parameter int BLK_SIZE = 128,
    parameter int XLEN     = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dc_valid_i,
    output logic                dc_ready_o,
    input  logic [XLEN-1:0]     dc_addr_i,
    input  logic                dc_rw_i,
    input  logic                dc_uncached_i,
    input  logic [BLK_SIZE-1:0] dc_wdata_i,
    output logic                dc_rsp_valid_o,
    output logic [BLK_SIZE-1:0] dc_rsp_data_o,
    input  logic                ic_valid_i,
    output logic                ic_ready_o,
    input  logic [XLEN-1:0]     ic_addr_i,
    output logic                ic_rsp_valid_o,
    output logic [BLK_SIZE-1:0] ic_rsp_data_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic                mem_we_o,
    output logic [31:0]         mem_wdata_o,
    input  logic                mem_rsp_valid_i,
    input  logic [31:0]         mem_rsp_data_i
);
    localparam int BEATS = BLK_SIZE / 32;
    localparam int OFF   = $clog2(BLK_SIZE / 8);
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [CW-1:0]       cnt, lane, idx;
    logic [XLEN-1:0]     addr_q;
    logic                rw_q, unc_q, ic_q;
    logic [BLK_SIZE-1:0] wdata_q, line_q;
    logic                dc_gnt, ic_gnt, grant, last_beat, in_req, in_resp;

`ifdef LOWX_ARB_RR_EN
    logic prefer_ic;
    assign dc_gnt = dc_valid_i && !(ic_valid_i && prefer_ic);
    always_ff @(posedge clk_i) begin
        if (rst_i) prefer_ic <= 1'b0;
        else if (grant) prefer_ic <= dc_gnt;
    end
`else
    assign dc_gnt = dc_valid_i;
`endif

    assign ic_gnt     = ic_valid_i && !dc_gnt;
    assign grant      = state == IDLE && !rst_i && (dc_valid_i || ic_valid_i);
    assign dc_ready_o = grant && dc_gnt;
    assign ic_ready_o = grant && ic_gnt;
    // Uncached writes pick the line lane selected by the word offset of the address.
    assign lane      = CW'((addr_q >> 2) & XLEN'(BEATS - 1));
    assign idx       = unc_q ? lane : cnt;
    assign last_beat = unc_q || cnt == LAST;
    assign in_req    = state == REQ && !rst_i;
    assign in_resp   = state == RESP && !rst_i;

    assign mem_req_valid_o = in_req;
    assign mem_we_o        = in_req && rw_q;
    assign mem_addr_o      = !in_req ? '0 :
                             unc_q ? {addr_q[XLEN-1:2], 2'b00} :
                             {addr_q[XLEN-1:OFF], OFF'(0)} + (XLEN'(cnt) << 2);
    assign mem_wdata_o     = in_req ? wdata_q[32*idx +: 32] : '0;
    assign dc_rsp_valid_o  = in_resp && !ic_q;
    assign ic_rsp_valid_o  = in_resp && ic_q;
    assign dc_rsp_data_o   = rst_i ? '0 : line_q;
    assign ic_rsp_data_o   = rst_i ? '0 : line_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (dc_valid_i || ic_valid_i) ? REQ : IDLE;
            REQ:     state_n = mem_req_ready_i ? WAIT : REQ;
            WAIT:    state_n = !mem_rsp_valid_i ? WAIT : last_beat ? RESP : REQ;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            unc_q   <= 1'b0;
            ic_q    <= 1'b0;
            wdata_q <= '0;
            line_q  <= '0;
        end else begin
            state <= state_n;
            if (grant) begin
                ic_q    <= !dc_gnt;
                addr_q  <= dc_gnt ? dc_addr_i : ic_addr_i;
                rw_q    <= dc_gnt && dc_rw_i;
                unc_q   <= dc_gnt && dc_uncached_i;
                wdata_q <= dc_gnt ? dc_wdata_i : '0;
                cnt     <= '0;
                line_q  <= '0;
            end
            if (state == WAIT && mem_rsp_valid_i) begin
                if (!rw_q && unc_q) line_q <= {BEATS{mem_rsp_data_i}};
                else if (!rw_q) line_q[32*cnt +: 32] <= mem_rsp_data_i;
                if (!last_beat) cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lowx_arbiter.sv
// tb_lowx_arbiter: directed scoreboard bench for lowx_arbiter (default 128-bit line).
module tb_lowx_arbiter;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         dc_valid_i, dc_ready_o, dc_rw_i, dc_uncached_i, dc_rsp_valid_o;
    logic [31:0]  dc_addr_i;
    logic [127:0] dc_wdata_i, dc_rsp_data_o;
    logic         ic_valid_i, ic_ready_o, ic_rsp_valid_o;
    logic [31:0]  ic_addr_i;
    logic [127:0] ic_rsp_data_o;
    logic         mem_req_valid_o, mem_req_ready_i, mem_we_o, mem_rsp_valid_i;
    logic [31:0]  mem_addr_o, mem_wdata_o, mem_rsp_data_i;

    lowx_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dc_valid_i(dc_valid_i), .dc_ready_o(dc_ready_o), .dc_addr_i(dc_addr_i),
        .dc_rw_i(dc_rw_i), .dc_uncached_i(dc_uncached_i), .dc_wdata_i(dc_wdata_i),
        .dc_rsp_valid_o(dc_rsp_valid_o), .dc_rsp_data_o(dc_rsp_data_o),
        .ic_valid_i(ic_valid_i), .ic_ready_o(ic_ready_o), .ic_addr_i(ic_addr_i),
        .ic_rsp_valid_o(ic_rsp_valid_o), .ic_rsp_data_o(ic_rsp_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {logic [31:0] addr; logic we; logic [31:0] wdata;} beat_t;
    typedef struct packed {logic ic; logic [127:0] data; int lat;} rsp_t;

`ifdef LOWX_ARB_RR_EN
    localparam logic EP2_IC = 1'b1;
`else
    localparam logic EP2_IC = 1'b0;
`endif

    beat_t       exp_beats[$];
    rsp_t        exp_rsp[$];
    logic [31:0] rd_q[$];
    int n_vec = 0, n_err = 0, cyc = 0, grant_cyc = 0;
    int rsp_extra = 0, stall_beat = -1, stall_left = 0, beat_no = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_line(input logic ic, input logic [31:0] a0, input int n, input logic we,
                             input logic [127:0] wr, input logic [127:0] rd,
                             input logic [127:0] data, input int lat);
        beat_t b;
        rsp_t  r;
        for (int i = 0; i < n; i++) begin
            b.addr  = a0 + 32'(4 * i);
            b.we    = we;
            b.wdata = wr[32*i +: 32];
            exp_beats.push_back(b);
            if (!we) rd_q.push_back(rd[32*i +: 32]);
        end
        r.ic = ic; r.data = data; r.lat = lat;
        exp_rsp.push_back(r);
    endtask

    task automatic issue(input logic ic, input logic [31:0] a, input logic rw, input logic unc,
                         input logic [127:0] wd);
        logic got = 1'b0;
        beat_no = 0;
        if (ic) begin
            ic_valid_i = 1'b1; ic_addr_i = a;
        end else begin
            dc_valid_i = 1'b1; dc_addr_i = a; dc_rw_i = rw; dc_uncached_i = unc; dc_wdata_i = wd;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (ic ? ic_ready_o : dc_ready_o) got = 1'b1;
            else @(negedge clk_i);
        end
        chk("grant", got, 1'b1);
        grant_cyc = cyc;
        @(negedge clk_i);
        dc_valid_i = 1'b0; ic_valid_i = 1'b0;
    endtask

    task automatic both(input logic exp_ic);
        logic got = 1'b0;
        beat_no = 0;
        if (exp_ic)
            push_line(1'b1, 32'h0000_0200, 4, 1'b0, '0, {32'hE3, 32'hE2, 32'hE1, 32'hE0},
                      {32'hE3, 32'hE2, 32'hE1, 32'hE0}, -1);
        else
            push_line(1'b0, 32'h0000_0100, 4, 1'b0, '0, {32'hD3, 32'hD2, 32'hD1, 32'hD0},
                      {32'hD3, 32'hD2, 32'hD1, 32'hD0}, -1);
        dc_valid_i = 1'b1; dc_addr_i = 32'h0000_0104; dc_rw_i = 1'b0; dc_uncached_i = 1'b0;
        ic_valid_i = 1'b1; ic_addr_i = 32'h0000_020C;
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (dc_ready_o || ic_ready_o) got = 1'b1;
            else @(negedge clk_i);
        end
        chk("grant_pair", {dc_ready_o, ic_ready_o}, exp_ic ? 2'b01 : 2'b10);
        grant_cyc = cyc;
        @(negedge clk_i);
        dc_valid_i = 1'b0; ic_valid_i = 1'b0;
        wait_done();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && (exp_rsp.size() != 0 || exp_beats.size() != 0); i++)
            @(negedge clk_i);
        chk("drain", 128'(exp_rsp.size() + exp_beats.size()), '0);
        repeat (2) @(negedge clk_i);
    endtask

    // Memory model: decides this cycle's ready/response after sampling the DUT mid-cycle.
    initial begin
        logic acc;
        int   pend = 0;
        mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
        forever begin
            @(negedge clk_i);
            #2;
            if (mem_req_valid_o && beat_no == stall_beat && stall_left > 0) begin
                mem_req_ready_i = 1'b0;
                stall_left--;
            end else mem_req_ready_i = 1'b1;
            acc = mem_req_valid_o && mem_req_ready_i;
            if (mem_req_valid_o) begin
                if (exp_beats.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_beat: got addr %h with no beat expected", mem_addr_o);
                end else begin
                    chk("beat_addr", mem_addr_o, exp_beats[0].addr);
                    chk("beat_we", mem_we_o, exp_beats[0].we);
                    chk("beat_wdata", mem_wdata_o, exp_beats[0].wdata);
                    if (acc) void'(exp_beats.pop_front());
                end
            end
            mem_rsp_valid_i = pend == 1;
            if (pend == 1) mem_rsp_data_i = rd_q.size() != 0 ? rd_q.pop_front() : '0;
            if (pend > 0) pend--;
            if (acc) begin
                pend = 1 + rsp_extra;
                beat_no++;
            end
        end
    end

    // Response monitor.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk_i);
            #2;
            if (dc_rsp_valid_o || ic_rsp_valid_o) begin
                if (exp_rsp.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_rsp: got dc=%b ic=%b with no response expected",
                             dc_rsp_valid_o, ic_rsp_valid_o);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_src", {dc_rsp_valid_o, ic_rsp_valid_o}, r.ic ? 2'b01 : 2'b10);
                    chk("rsp_data", r.ic ? ic_rsp_data_o : dc_rsp_data_o, r.data);
                    if (r.lat >= 0) chk("rsp_latency", 128'(cyc - grant_cyc + 1), 128'(r.lat));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        beat_t b;
        rst_i = 1'b1;
        dc_valid_i = 1'b1; dc_addr_i = 32'h0000_1234; dc_rw_i = 1'b0; dc_uncached_i = 1'b0;
        dc_wdata_i = '0; ic_valid_i = 1'b1; ic_addr_i = '0;
        repeat (3) @(negedge clk_i);
        #2;
        chk("rst_ready", {dc_ready_o, ic_ready_o}, '0);
        chk("rst_mem", {mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o}, '0);
        chk("rst_rsp", {dc_rsp_valid_o, ic_rsp_valid_o}, '0);
        chk("rst_data", dc_rsp_data_o | ic_rsp_data_o, '0);
        @(negedge clk_i);
        dc_valid_i = 1'b0; ic_valid_i = 1'b0; rst_i = 1'b0;
        @(negedge clk_i);

        both(1'b0);
        both(EP2_IC);

        push_line(1'b0, 32'h0000_1230, 4, 1'b0, '0, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
                  {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 10);
        issue(1'b0, 32'h0000_1234, 1'b0, 1'b0, '0);
        wait_done();

        push_line(1'b0, 32'h8000_0040, 4, 1'b1, {32'h4444, 32'h3333, 32'h2222, 32'h1111}, '0, '0, -1);
        issue(1'b0, 32'h8000_0040, 1'b1, 1'b0, {32'h4444, 32'h3333, 32'h2222, 32'h1111});
        wait_done();

        push_line(1'b0, 32'h2000_0008, 1, 1'b0, '0, {96'h0, 32'hDEADBEEF}, {4{32'hDEADBEEF}}, -1);
        issue(1'b0, 32'h2000_0008, 1'b0, 1'b1, '0);
        wait_done();

        push_line(1'b0, 32'h3000_0008, 1, 1'b1, {96'h0, 32'hC2C2_C2C2}, '0, '0, -1);
        issue(1'b0, 32'h3000_000A, 1'b1, 1'b1,
              {32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0});
        wait_done();

        push_line(1'b1, 32'h0000_9AB0, 4, 1'b0, '0, {32'hF3, 32'hF2, 32'hF1, 32'hF0},
                  {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 10);
        issue(1'b1, 32'h0000_9ABC, 1'b0, 1'b0, '0);
        wait_done();

        stall_beat = 2; stall_left = 3;
        push_line(1'b0, 32'h0000_5670, 4, 1'b0, '0, {32'hB3, 32'hB2, 32'hB1, 32'hB0},
                  {32'hB3, 32'hB2, 32'hB1, 32'hB0}, -1);
        issue(1'b0, 32'h0000_5678, 1'b0, 1'b0, '0);
        wait_done();
        chk("stall_used", 128'(stall_left), '0);
        stall_beat = -1;

        rsp_extra = 1;
        b.addr = 32'h0000_7770; b.we = 1'b0; b.wdata = '0;
        exp_beats.push_back(b);
        rd_q.push_back(32'h0000_00F0);
        issue(1'b0, 32'h0000_7774, 1'b0, 1'b0, '0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #2;
        chk("midrst_mem", {mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o}, '0);
        chk("midrst_rsp", {dc_rsp_valid_o, ic_rsp_valid_o}, '0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (6) @(negedge clk_i);
        #2;
        chk("postrst_mem", {mem_req_valid_o, mem_addr_o}, '0);
        chk("postrst_data", dc_rsp_data_o | ic_rsp_data_o, '0);
        chk("late_rsp_sent", 128'(rd_q.size()), '0);
        rsp_extra = 0;

        repeat (3) @(negedge clk_i);
        chk("final_empty", 128'(exp_rsp.size() + exp_beats.size() + rd_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
